// File: rtl/sextium_io_fifo.sv
// rtl/sextium_io_fifo.sv - Avalon-MM slave bridging the Sextium I/O port to RX/TX word FIFOs
module sextium_io_fifo #(
  parameter int          DEPTH_LOG2      = 4,
  parameter logic [31:0] READ_FIFO_ADDR  = 32'h0020_0006,
  parameter logic [31:0] WRITE_FIFO_ADDR = 32'h0020_0008,
  parameter logic [31:0] STATUS_ADDR     = 32'h0020_000A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  output logic [15:0] readdata,
  output logic        waitrequest,
  input  logic        write,
  input  logic [15:0] writedata,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int D  = 1 << DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0]         CNT_ONE  = 1;
  localparam logic [CW-1:0]         CNT_FULL = CW'(D);

  logic [15:0]           r_rx_mem [D];
  logic [15:0]           r_tx_mem [D];
  logic [DEPTH_LOG2-1:0] r_rx_wr_ptr, r_rx_rd_ptr, r_tx_wr_ptr, r_tx_rd_ptr;
  logic [CW-1:0]         r_rx_count, r_tx_count;
  logic                  r_rx_ready;
  logic [CW-1:0]         w_rx_count_nxt, w_tx_count_nxt;

  logic w_rd_fifo, w_rd_stat, w_wr_fifo;
  logic w_rx_empty, w_tx_empty, w_tx_full;
  logic w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;

  // A read takes priority, so a write only decodes when read is low
  assign w_rd_fifo = read && (address == READ_FIFO_ADDR);
  assign w_rd_stat = read && (address == STATUS_ADDR);
  assign w_wr_fifo = !read && write && (address == WRITE_FIFO_ADDR);

  assign w_rx_empty = (r_rx_count == '0);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == CNT_FULL);

  assign w_rx_push = rx_valid && r_rx_ready;
  assign w_rx_pop  = reset && w_rd_fifo && !w_rx_empty;
  assign w_tx_push = reset && w_wr_fifo && !w_tx_full;
  assign w_tx_pop  = tx_valid && tx_ready;

  assign rx_ready    = r_rx_ready;
  assign tx_valid    = !w_tx_empty;
  assign tx_data     = r_tx_mem[r_tx_rd_ptr];
  assign waitrequest = !reset || (w_rd_fifo && w_rx_empty) || (w_wr_fifo && w_tx_full);

  always_comb begin
    readdata = '0;
    if (reset) begin
      if (w_rd_fifo)
        readdata = r_rx_mem[r_rx_rd_ptr];
      else if (w_rd_stat)
        readdata = {8'(r_rx_count), 8'(r_tx_count)};
    end
  end

  always_comb begin
    w_rx_count_nxt = r_rx_count;
    if (w_rx_push && !w_rx_pop)
      w_rx_count_nxt = r_rx_count + CNT_ONE;
    else if (!w_rx_push && w_rx_pop)
      w_rx_count_nxt = r_rx_count - CNT_ONE;
  end

  always_comb begin
    w_tx_count_nxt = r_tx_count;
    if (w_tx_push && !w_tx_pop)
      w_tx_count_nxt = r_tx_count + CNT_ONE;
    else if (!w_tx_push && w_tx_pop)
      w_tx_count_nxt = r_tx_count - CNT_ONE;
  end

  // rx_ready is registered from the next count, so a pop never opens space combinationally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_rx_ready  <= 1'b0;
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + PTR_ONE;
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + PTR_ONE;
      r_rx_count <= w_rx_count_nxt;
      r_tx_count <= w_tx_count_nxt;
      r_rx_ready <= (w_rx_count_nxt != CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= writedata;
  end

endmodule

// File: tb/tb_sextium_io_fifo.sv
// tb/tb_sextium_io_fifo.sv - directed self-checking bench for sextium_io_fifo
module tb_sextium_io_fifo;

  localparam logic [31:0] A_RD   = 32'h0020_0006;
  localparam logic [31:0] A_WR   = 32'h0020_0008;
  localparam logic [31:0] A_STAT = 32'h0020_000A;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read, write;
  logic [15:0] readdata, writedata;
  logic        waitrequest;
  logic [15:0] rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  sextium_io_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .write(write), .writedata(writedata),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read = 0; write = 0; address = '0; writedata = '0;
    rx_valid = 0; rx_data = '0; tx_ready = 0;
  endtask

  task automatic rx_push(input logic [15:0] d);
    rx_valid = 1; rx_data = d;
    #1;
    check("rx_push_ready", rx_ready, 1);
    next();
    rx_valid = 0;
  endtask

  task automatic rx_pop(input string tag, input logic [15:0] exp);
    read = 1; address = A_RD;
    #1;
    check(tag, {waitrequest, readdata}, {1'b0, exp});
    next();
    read = 0; address = '0;
  endtask

  task automatic tx_write(input logic [15:0] d);
    write = 1; address = A_WR; writedata = d;
    #1;
    check("tx_write_wait", waitrequest, 0);
    next();
    write = 0; address = '0;
  endtask

  task automatic status(input string tag, input logic [15:0] exp);
    read = 1; address = A_STAT;
    #1;
    check(tag, {waitrequest, readdata}, {1'b0, exp});
    next();
    read = 0; address = '0;
  endtask

  initial begin
    idle();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_wait", waitrequest, 1);
    check("rst_readdata", readdata, 0);
    reset = 1;
    #1;
    check("rel_rx_ready_pre", rx_ready, 0);
    next();
    check("rel_rx_ready_post", rx_ready, 1);
    check("rel_tx_valid", tx_valid, 0);
    status("rst_status", 16'h0000);

    // RX path with zero-wait pop then a stalled pop
    rx_push(16'hBEEF);
    rx_pop("rx_beef", 16'hBEEF);
    read = 1; address = A_RD;
    #1;
    check("rx_stall0", waitrequest, 1);
    next();
    check("rx_stall1", waitrequest, 1);
    rx_valid = 1; rx_data = 16'h1234;
    #1;
    check("rx_stall2", waitrequest, 1);
    next();
    rx_valid = 0;
    #1;
    check("rx_after_stall", {waitrequest, readdata}, {1'b0, 16'h1234});
    next();
    read = 0; address = '0;
    status("rx_empty_status", 16'h0000);

    // RX fill with valid held high; the 17th word must be refused
    for (int i = 0; i < 17; i++) begin
      rx_valid = 1; rx_data = 16'(i);
      #1;
      check($sformatf("rx_fill_ready_%0d", i), rx_ready, (i < 16) ? 1 : 0);
      next();
    end
    rx_valid = 0;
    status("rx_full_status", 16'h1000);
    for (int i = 0; i < 16; i++) rx_pop($sformatf("rx_drain_%0d", i), 16'(i));
    for (int i = 0; i < 10; i++) rx_push(16'h0100 + 16'(i));
    for (int i = 0; i < 10; i++) rx_pop($sformatf("rx_wrap_a_%0d", i), 16'h0100 + 16'(i));
    for (int i = 0; i < 10; i++) rx_push(16'h0110 + 16'(i));
    for (int i = 0; i < 10; i++) rx_pop($sformatf("rx_wrap_b_%0d", i), 16'h0110 + 16'(i));

    // TX back-pressure
    for (int i = 0; i < 16; i++) tx_write(16'h0200 + 16'(i));
    write = 1; address = A_WR; writedata = 16'h02FF;
    #1;
    check("tx_full_wait0", waitrequest, 1);
    next();
    check("tx_full_wait1", waitrequest, 1);
    check("tx_head_valid", {tx_valid, tx_data}, {1'b1, 16'h0200});
    tx_ready = 1;
    #1;
    check("tx_full_wait2", waitrequest, 1);
    next();
    tx_ready = 0;
    #1;
    check("tx_space_wait", waitrequest, 0);
    check("tx_next_head", tx_data, 16'h0201);
    next();
    write = 0; address = '0;
    status("tx_full_status", 16'h0010);

    // Drain TX to 5 words, then concurrent push and pop
    tx_ready = 1;
    for (int i = 1; i < 12; i++) begin
      #1;
      check($sformatf("tx_drain_%0d", i), tx_data, 16'h0200 + 16'(i));
      next();
    end
    tx_ready = 0;
    status("tx5_status", 16'h0005);
    write = 1; address = A_WR; writedata = 16'h0300; tx_ready = 1;
    #1;
    check("tx_conc", {waitrequest, tx_data}, {1'b0, 16'h020C});
    next();
    idle();
    status("tx_conc_status", 16'h0005);
    rx_push(16'h0400);
    rx_push(16'h0401);
    rx_valid = 1; rx_data = 16'h0402;
    read = 1; address = A_RD;
    #1;
    check("rx_conc", {waitrequest, readdata}, {1'b0, 16'h0400});
    next();
    idle();
    status("rx_conc_status", 16'h0205);

    // Decode corners
    read = 1; write = 1; address = A_RD; writedata = 16'hDEAD;
    #1;
    check("rdwr_rdaddr", {waitrequest, readdata}, {1'b0, 16'h0401});
    next();
    address = A_WR;
    #1;
    check("rdwr_wraddr", {waitrequest, readdata}, {1'b0, 16'h0000});
    next();
    idle();
    status("rdwr_status", 16'h0105);
    write = 1; address = 32'h0020_0000; writedata = 16'hAAAA;
    #1;
    check("unmapped_wr_wait", waitrequest, 0);
    next();
    idle();
    read = 1; address = 32'h0020_0000;
    #1;
    check("unmapped_rd", {waitrequest, readdata}, {1'b0, 16'h0000});
    next();
    idle();
    status("unmapped_status", 16'h0105);

    // Reset during a stalled read
    rx_pop("rx_last", 16'h0402);
    read = 1; address = A_RD;
    #1;
    check("pre_rst_stall", waitrequest, 1);
    reset = 0;
    #1;
    check("mid_rst_wait", waitrequest, 1);
    check("mid_rst_rx_ready", rx_ready, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    next();
    idle();
    reset = 1;
    next();
    status("post_rst_status", 16'h0000);
    check("post_rst_tx_valid", tx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
